// File: rtl/eei_batch_ctrl_if.sv
// Snapshot-regfile request channel between the batch sequencer (master)
// and the snapshot regfile (slave).
interface eei_batch_ctrl_if #(
  parameter int unsigned RS_MAX = 8
);

  logic                     sreg_req;
  logic [6:0]               sreg_funct7;
  logic [4:0]               sreg_batch_start;
  logic [4:0]               sreg_batch_len;
  logic [RS_MAX-1:0][31:0]  sreg_rs_val;
  logic                     sreg_ack;
  logic                     sreg_error;
  logic [RS_MAX-1:0][31:0]  sreg_rd_val;

  modport master (
    output sreg_req,
    output sreg_funct7,
    output sreg_batch_start,
    output sreg_batch_len,
    output sreg_rs_val,
    input  sreg_ack,
    input  sreg_error,
    input  sreg_rd_val
  );

  modport slave (
    input  sreg_req,
    input  sreg_funct7,
    input  sreg_batch_start,
    input  sreg_batch_len,
    input  sreg_rs_val,
    output sreg_ack,
    output sreg_error,
    output sreg_rd_val
  );

endinterface

// File: rtl/eei_batch_ctrl.sv
// Batch sequencer: gathers a contiguous GPR run for a snapshot save, or
// scatters snapshot data back into the GPRs for a restore, issuing one
// batched request to the snapshot regfile per command.
module eei_batch_ctrl #(
  parameter int unsigned RS_MAX = 8,
  parameter int unsigned RP     = 2,
  parameter int unsigned WP     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  req_ready_o,
  input  logic [6:0]            req_funct7_i,
  input  logic [4:0]            req_start_i,
  input  logic [4:0]            req_len_i,
  output logic                  done_o,
  output logic                  error_o,
  output logic [RP-1:0][4:0]    gpr_rd_addr_o,
  input  logic [RP-1:0][31:0]   gpr_rd_data_i,
  output logic [WP-1:0]         gpr_we_o,
  output logic [WP-1:0][4:0]    gpr_wr_addr_o,
  output logic [WP-1:0][31:0]   gpr_wr_data_o,
  eei_batch_ctrl_if.master      sreg
);

  localparam logic [6:0] F7_SAVE    = 7'b0000000;
  localparam logic [6:0] F7_RESTORE = 7'b1000000;
  localparam logic [5:0] RP_STEP    = 6'(RP);
  localparam logic [5:0] WP_STEP    = 6'(WP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_ISSUE,
    S_SCATTER,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [6:0]              funct7_q;
  logic [4:0]              start_q;
  logic [4:0]              len_q;
  logic [5:0]              idx_q, idx_d;
  logic                    err_q, err_d;
  logic [RS_MAX-1:0][31:0] buf_q;
  logic                    accept;
  logic                    capture;
  logic [5:0]              len_ext;
  logic [5:0]              range_end;

  assign len_ext   = {1'b0, len_q};
  assign range_end = {1'b0, req_start_i} + {1'b0, req_len_i};

  assign sreg.sreg_funct7      = funct7_q;
  assign sreg.sreg_batch_start = start_q;
  assign sreg.sreg_batch_len   = len_q;
  assign sreg.sreg_rs_val      = buf_q;

  // Next-state, handshake and completion outputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    err_d         = err_q;
    accept        = 1'b0;
    capture       = 1'b0;
    req_ready_o   = 1'b0;
    done_o        = 1'b0;
    error_o       = 1'b0;
    sreg.sreg_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_i) begin
          accept = 1'b1;
          idx_d  = '0;
          err_d  = 1'b0;
          if (req_len_i == 5'd0) begin
            state_d = S_DONE;
          end else if ((32'(req_len_i) > RS_MAX) || (range_end > 6'd32)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (req_funct7_i == F7_SAVE) begin
            state_d = S_GATHER;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_GATHER: begin
        idx_d = idx_q + RP_STEP;
        if ((idx_q + RP_STEP) >= len_ext) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sreg.sreg_req = 1'b1;
        if (sreg.sreg_ack) begin
          if (sreg.sreg_error) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (funct7_q == F7_RESTORE) begin
            state_d = S_SCATTER;
            idx_d   = '0;
            capture = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SCATTER: begin
        idx_d = idx_q + WP_STEP;
        if ((idx_q + WP_STEP) >= len_ext) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        error_o = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // GPR read addresses for the current gather slice; idle ports read x0
  always_comb begin
    for (int unsigned p = 0; p < RP; p++) begin
      gpr_rd_addr_o[p] = '0;
      if ((state_q == S_GATHER) && ((idx_q + 6'(p)) < len_ext)) begin
        gpr_rd_addr_o[p] = start_q + 5'(idx_q + 6'(p));
      end
    end
  end

  // GPR write ports for the current scatter slice; x0 target consumes its slot without writing
  always_comb begin
    for (int unsigned w = 0; w < WP; w++) begin
      gpr_we_o[w]      = 1'b0;
      gpr_wr_addr_o[w] = '0;
      gpr_wr_data_o[w] = '0;
      if ((state_q == S_SCATTER) && ((idx_q + 6'(w)) < len_ext)) begin
        gpr_wr_addr_o[w] = start_q + 5'(idx_q + 6'(w));
        gpr_we_o[w]      = (gpr_wr_addr_o[w] != 5'd0);
        for (int unsigned i = 0; i < RS_MAX; i++) begin
          if ((idx_q + 6'(w)) == 6'(i)) begin
            gpr_wr_data_o[w] = buf_q[i];
          end
        end
      end
    end
  end

  // State, command latch and operand buffer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      err_q    <= 1'b0;
      funct7_q <= '0;
      start_q  <= '0;
      len_q    <= '0;
      buf_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      if (accept) begin
        funct7_q <= req_funct7_i;
        start_q  <= req_start_i;
        len_q    <= req_len_i;
        buf_q    <= '0;
      end
      if (state_q == S_GATHER) begin
        for (int unsigned i = 0; i < RS_MAX; i++) begin
          for (int unsigned p = 0; p < RP; p++) begin
            if (((idx_q + 6'(p)) == 6'(i)) && (6'(i) < len_ext)) begin
              buf_q[i] <= gpr_rd_data_i[p];
            end
          end
        end
      end
      // Entries beyond len stay zero so sreg_rs_val never exposes stale data
      if (capture) begin
        for (int unsigned i = 0; i < RS_MAX; i++) begin
          buf_q[i] <= (6'(i) < len_ext) ? sreg.sreg_rd_val[i] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_eei_batch_ctrl.sv
// Directed bench for eei_batch_ctrl: acts as the GPR file and the
// snapshot regfile and checks each step against hand-computed values.
module tb_eei_batch_ctrl;

  localparam int unsigned RS_MAX = 8;
  localparam int unsigned RP     = 2;
  localparam int unsigned WP     = 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req = 1'b0;
  logic                  ready;
  logic [6:0]            f7 = '0;
  logic [4:0]            start = '0;
  logic [4:0]            len = '0;
  logic                  done;
  logic                  error_s;
  logic [RP-1:0][4:0]    rd_addr;
  logic [RP-1:0][31:0]   rd_data;
  logic [WP-1:0]         we;
  logic [WP-1:0][4:0]    wr_addr;
  logic [WP-1:0][31:0]   wr_data;

  eei_batch_ctrl_if #(.RS_MAX(RS_MAX)) sif ();

  eei_batch_ctrl #(.RS_MAX(RS_MAX), .RP(RP), .WP(WP)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .req_ready_o   (ready),
    .req_funct7_i  (f7),
    .req_start_i   (start),
    .req_len_i     (len),
    .done_o        (done),
    .error_o       (error_s),
    .gpr_rd_addr_o (rd_addr),
    .gpr_rd_data_i (rd_data),
    .gpr_we_o      (we),
    .gpr_wr_addr_o (wr_addr),
    .gpr_wr_data_o (wr_data),
    .sreg          (sif)
  );

  always #5 clk = ~clk;

  logic [31:0] gpr_mem [32];

  always_comb begin
    for (int p = 0; p < RP; p++) rd_data[p] = gpr_mem[rd_addr[p]];
  end

  int unsigned req_cycles = 0;
  int unsigned wr_total   = 0;
  int unsigned done_total = 0;
  logic [31:0] wr_log [32] = '{default: '0};

  always @(posedge clk) begin
    if (sif.sreg_req) req_cycles <= req_cycles + 1;
    if (done) done_total <= done_total + 1;
    for (int w = 0; w < WP; w++) begin
      if (we[w]) begin
        wr_log[wr_addr[w]] <= wr_data[w];
        wr_total <= wr_total + 1;
      end
    end
  end

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned rq0, wr0, dn0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap;
    rq0 = req_cycles;
    wr0 = wr_total;
    dn0 = done_total;
  endtask

  initial begin
    sif.sreg_ack    = 1'b0;
    sif.sreg_error  = 1'b0;
    sif.sreg_rd_val = '0;
    for (int n = 0; n < 32; n++) gpr_mem[n] = 32'h100 + 32'(n);

    // Reset state
    tick;
    tick;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error_s), 32'd0);
    chk("rst_sreq", 32'(sif.sreg_req), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_rdaddr0", 32'(rd_addr[0]), 32'd0);
    chk("rst_f7", 32'(sif.sreg_funct7), 32'd0);
    chk("rst_rs0", sif.sreg_rs_val[0], 32'd0);
    rst = 1'b0;
    tick;

    // Save: start 4, len 5, ack held high
    snap();
    sif.sreg_ack = 1'b1;
    req = 1'b1; f7 = 7'h00; start = 5'd4; len = 5'd5;
    chk("save_ready", 32'(ready), 32'd1);
    tick; req = 1'b0;
    chk("save_g1_a0", 32'(rd_addr[0]), 32'd4);
    chk("save_g1_a1", 32'(rd_addr[1]), 32'd5);
    chk("save_g1_ready", 32'(ready), 32'd0);
    tick;
    chk("save_g2_a0", 32'(rd_addr[0]), 32'd6);
    chk("save_g2_a1", 32'(rd_addr[1]), 32'd7);
    tick;
    chk("save_g3_a0", 32'(rd_addr[0]), 32'd8);
    chk("save_g3_a1", 32'(rd_addr[1]), 32'd0);
    tick;
    chk("save_issue_req", 32'(sif.sreg_req), 32'd1);
    chk("save_issue_f7", 32'(sif.sreg_funct7), 32'h00);
    chk("save_issue_start", 32'(sif.sreg_batch_start), 32'd4);
    chk("save_issue_len", 32'(sif.sreg_batch_len), 32'd5);
    for (int i = 0; i < RS_MAX; i++)
      chk($sformatf("save_rs%0d", i), sif.sreg_rs_val[i], (i < 5) ? 32'h104 + 32'(i) : 32'd0);
    tick;
    chk("save_done", 32'(done), 32'd1);
    chk("save_error", 32'(error_s), 32'd0);
    chk("save_done_sreq", 32'(sif.sreg_req), 32'd0);
    tick;
    chk("save_after_done", 32'(done), 32'd0);
    chk("save_after_ready", 32'(ready), 32'd1);
    chk("save_req_cycles", req_cycles - rq0, 32'd1);
    chk("save_writes", wr_total - wr0, 32'd0);
    chk("save_done_count", done_total - dn0, 32'd1);
    sif.sreg_ack = 1'b0;

    // Restore: start 0, len 3, x0 write suppressed
    snap();
    for (int i = 0; i < RS_MAX; i++) sif.sreg_rd_val[i] = 32'hA + 32'(i);
    sif.sreg_ack = 1'b1;
    req = 1'b1; f7 = 7'h40; start = 5'd0; len = 5'd3;
    tick; req = 1'b0;
    chk("rest_issue_req", 32'(sif.sreg_req), 32'd1);
    chk("rest_issue_we", 32'(we), 32'd0);
    tick;
    chk("rest_s0_we", 32'(we), 32'd0);
    chk("rest_s0_addr", 32'(wr_addr[0]), 32'd0);
    tick;
    chk("rest_s1_we", 32'(we), 32'd1);
    chk("rest_s1_addr", 32'(wr_addr[0]), 32'd1);
    chk("rest_s1_data", wr_data[0], 32'hB);
    tick;
    chk("rest_s2_we", 32'(we), 32'd1);
    chk("rest_s2_addr", 32'(wr_addr[0]), 32'd2);
    chk("rest_s2_data", wr_data[0], 32'hC);
    chk("rest_s2_sreq", 32'(sif.sreg_req), 32'd0);
    tick;
    chk("rest_done", 32'(done), 32'd1);
    chk("rest_error", 32'(error_s), 32'd0);
    chk("rest_done_we", 32'(we), 32'd0);
    chk("rest_rs3", sif.sreg_rs_val[3], 32'd0);
    tick;
    chk("rest_x1", wr_log[1], 32'hB);
    chk("rest_x2", wr_log[2], 32'hC);
    chk("rest_x0", wr_log[0], 32'd0);
    chk("rest_writes", wr_total - wr0, 32'd2);
    chk("rest_done_count", done_total - dn0, 32'd1);
    sif.sreg_ack = 1'b0;

    // Range error: start 30, len 3
    snap();
    req = 1'b1; f7 = 7'h00; start = 5'd30; len = 5'd3;
    tick; req = 1'b0;
    chk("range_done", 32'(done), 32'd1);
    chk("range_error", 32'(error_s), 32'd1);
    chk("range_sreq", 32'(sif.sreg_req), 32'd0);
    tick;
    chk("range_req_cycles", req_cycles - rq0, 32'd0);
    chk("range_writes", wr_total - wr0, 32'd0);
    chk("range_done_count", done_total - dn0, 32'd1);

    // Length above RS_MAX (start+len still in range)
    snap();
    req = 1'b1; f7 = 7'h00; start = 5'd0; len = 5'd9;
    tick; req = 1'b0;
    chk("long_done", 32'(done), 32'd1);
    chk("long_error", 32'(error_s), 32'd1);
    tick;
    chk("long_req_cycles", req_cycles - rq0, 32'd0);

    // Zero length
    snap();
    req = 1'b1; f7 = 7'h40; start = 5'd5; len = 5'd0;
    tick; req = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_error", 32'(error_s), 32'd0);
    tick;
    chk("zero_req_cycles", req_cycles - rq0, 32'd0);
    chk("zero_writes", wr_total - wr0, 32'd0);

    // Stalled ack with error, unknown funct7
    snap();
    req = 1'b1; f7 = 7'h7F; start = 5'd3; len = 5'd2;
    tick; req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("stall_req_c%0d", k), 32'(sif.sreg_req), 32'd1);
      chk($sformatf("stall_f7_c%0d", k), 32'(sif.sreg_funct7), 32'h7F);
      chk($sformatf("stall_start_c%0d", k), 32'(sif.sreg_batch_start), 32'd3);
      chk($sformatf("stall_len_c%0d", k), 32'(sif.sreg_batch_len), 32'd2);
      chk($sformatf("stall_done_c%0d", k), 32'(done), 32'd0);
      if (k == 4) begin
        sif.sreg_ack   = 1'b1;
        sif.sreg_error = 1'b1;
      end
      tick;
    end
    chk("stall_rs0", sif.sreg_rs_val[0], 32'd0);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_error", 32'(error_s), 32'd1);
    chk("stall_done_sreq", 32'(sif.sreg_req), 32'd0);
    sif.sreg_ack   = 1'b0;
    sif.sreg_error = 1'b0;
    tick;
    chk("stall_req_cycles", req_cycles - rq0, 32'd4);
    chk("stall_writes", wr_total - wr0, 32'd0);

    // Reset during scatter: restore start 8, len 8
    snap();
    for (int i = 0; i < RS_MAX; i++) sif.sreg_rd_val[i] = 32'h200 + 32'(i);
    sif.sreg_ack = 1'b1;
    req = 1'b1; f7 = 7'h40; start = 5'd8; len = 5'd8;
    tick; req = 1'b0;
    tick;
    chk("rsc_w1_addr", 32'(wr_addr[0]), 32'd8);
    chk("rsc_w1_data", wr_data[0], 32'h200);
    tick;
    chk("rsc_w2_addr", 32'(wr_addr[0]), 32'd9);
    chk("rsc_w2_data", wr_data[0], 32'h201);
    tick;
    chk("rsc_w3_pending", 32'(we), 32'd1);
    rst = 1'b1;
    #2;
    chk("rsc_rst_we", 32'(we), 32'd0);
    chk("rsc_rst_ready", 32'(ready), 32'd1);
    chk("rsc_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sif.sreg_ack = 1'b0;
    chk("rsc_ready_next", 32'(ready), 32'd1);
    tick;
    tick;
    chk("rsc_writes", wr_total - wr0, 32'd2);
    chk("rsc_done_count", done_total - dn0, 32'd0);
    chk("rsc_x8", wr_log[8], 32'h200);
    chk("rsc_x9", wr_log[9], 32'h201);
    chk("rsc_x10", wr_log[10], 32'd0);
    chk("rsc_len_cleared", 32'(sif.sreg_batch_len), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
